// File: rtl/fpu_floor_arb.sv
// Round-robin arbiter sharing one combinational floor unit between two requesters.
// Optional perf counters are enabled with FPU_FLOOR_ARB_PERF_EN.
module fpu_floor_arb #(
   parameter int unsigned TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [31:0]      req0_data,
   input  logic [TAG_W-1:0] req0_tag,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [31:0]      req1_data,
   input  logic [TAG_W-1:0] req1_tag,
   output logic [31:0]      unit_s,
   input  logic [31:0]      unit_d,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [31:0]      resp_data,
   output logic [TAG_W-1:0] resp_tag,
   output logic             resp_port
`ifdef FPU_FLOOR_ARB_PERF_EN
   ,
   output logic [31:0]      perf_grant0,
   output logic [31:0]      perf_grant1,
   output logic [31:0]      perf_stall
`endif
);

   typedef enum logic [1:0] {StIdle, StCalc, StHold} state_e;

   state_e           state_q, state_d;
   logic             last_q, last_d;
   logic [31:0]      unit_s_q, unit_s_d;
   logic [TAG_W-1:0] tag_q, tag_d;
   logic [31:0]      resp_data_q, resp_data_d;
   logic [TAG_W-1:0] resp_tag_q, resp_tag_d;
   logic             resp_port_q, resp_port_d;
   logic             gnt0, gnt1, fire0, fire1;

   // Grant only in IDLE; on a tie the port that did not win last time goes next.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (state_q == StIdle && !rst) begin
         if (req0_valid && req1_valid) begin
            gnt0 = last_q;
            gnt1 = !last_q;
         end else begin
            gnt0 = req0_valid;
            gnt1 = req1_valid;
         end
      end
   end

   assign req0_ready = gnt0;
   assign req1_ready = gnt1;
   assign fire0      = req0_valid && gnt0;
   assign fire1      = req1_valid && gnt1;

   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      unit_s_d    = unit_s_q;
      tag_d       = tag_q;
      resp_data_d = resp_data_q;
      resp_tag_d  = resp_tag_q;
      resp_port_d = resp_port_q;
      unique case (state_q)
         StIdle: begin
            if (fire0) begin
               unit_s_d    = req0_data;
               tag_d       = req0_tag;
               resp_port_d = 1'b0;
               last_d      = 1'b0;
               state_d     = StCalc;
            end else if (fire1) begin
               unit_s_d    = req1_data;
               tag_d       = req1_tag;
               resp_port_d = 1'b1;
               last_d      = 1'b1;
               state_d     = StCalc;
            end
         end
         StCalc: begin
            resp_data_d = unit_d;
            resp_tag_d  = tag_q;
            state_d     = StHold;
         end
         StHold: begin
            if (resp_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         last_q      <= 1'b1;
         unit_s_q    <= '0;
         tag_q       <= '0;
         resp_data_q <= '0;
         resp_tag_q  <= '0;
         resp_port_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         unit_s_q    <= unit_s_d;
         tag_q       <= tag_d;
         resp_data_q <= resp_data_d;
         resp_tag_q  <= resp_tag_d;
         resp_port_q <= resp_port_d;
      end
   end

   assign unit_s     = unit_s_q;
   assign resp_valid = (state_q == StHold);
   assign resp_data  = resp_data_q;
   assign resp_tag   = resp_tag_q;
   assign resp_port  = resp_port_q;

`ifdef FPU_FLOOR_ARB_PERF_EN
   logic [31:0] perf_grant0_q, perf_grant0_d;
   logic [31:0] perf_grant1_q, perf_grant1_d;
   logic [31:0] perf_stall_q, perf_stall_d;

   always_comb begin
      perf_grant0_d = perf_grant0_q + {31'd0, fire0};
      perf_grant1_d = perf_grant1_q + {31'd0, fire1};
      perf_stall_d  = perf_stall_q + {31'd0, resp_valid && !resp_ready};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         perf_grant0_q <= '0;
         perf_grant1_q <= '0;
         perf_stall_q  <= '0;
      end else begin
         perf_grant0_q <= perf_grant0_d;
         perf_grant1_q <= perf_grant1_d;
         perf_stall_q  <= perf_stall_d;
      end
   end

   assign perf_grant0 = perf_grant0_q;
   assign perf_grant1 = perf_grant1_q;
   assign perf_stall  = perf_stall_q;
`endif

endmodule
